// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared constants and types for the SoC data-RAM path.
//   BYTE_LANES  - byte lanes per RAM word (one bank per lane)
//   DEF_RAM_AW  - default RAM word-address width (8 KiB / 4 bytes)
//   MST_CORE    - master ID of the core load/store port (m0)
//   MST_LOADER  - master ID of the program loader/debug port (m1)
//   arb_state_t - arbiter priority state
package riscv_mem_pkg;

  localparam int BYTE_LANES = 4;
  localparam int DEF_RAM_AW = 11;

  localparam logic MST_CORE   = 1'b0;
  localparam logic MST_LOADER = 1'b1;

  typedef enum logic {
    PRIO_M0  = 1'b0,  // core wins contested cycles
    FORCE_M1 = 1'b1   // loader has waited long enough and wins
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single data-RAM port between the core (m0)
// and the loader/debug port (m1). m0 has fixed priority; a starvation
// counter force-grants m1 after MAX_WAIT consecutive lost cycles. Read data
// is routed back to the issuing master one cycle after its grant.
//
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   m0_* / m1_*               - master request/payload in; gnt, rdata,
//                               rvalid out (transfer on req && gnt)
//   ram_en, ram_we, ram_addr,
//   ram_wdata                 - RAM access of the granted master
//   ram_rdata                 - RAM read data, valid the cycle after a read
module ram_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RAM_AW   = DEF_RAM_AW,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  m0_req,
  input  logic [BYTE_LANES-1:0] m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_rvalid,

  input  logic                  m1_req,
  input  logic [BYTE_LANES-1:0] m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_rvalid,

  output logic                  ram_en,
  output logic [BYTE_LANES-1:0] ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_t            state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt, wait_nxt;
  logic                  rd_pend;
  logic                  rd_owner;

  logic [BYTE_LANES-1:0] sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  // Byte offset and upper address bits are intentionally dropped (the RAM
  // aliases across the whole master address space).
  logic [ADDR_W-1:0]     unused_addr;

  // ---------------------------------------------------------------------
  // Grant. Combinational from req and registered state; gated by rstn so
  // nothing is granted while reset is held.
  // ---------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rstn) begin
      if (state == FORCE_M1) begin
        m1_gnt = m1_req;
        m0_gnt = m0_req & ~m1_req;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req & ~m0_req;
      end
    end
  end

  // ---------------------------------------------------------------------
  // RAM payload mux: granted master's payload, all zero when idle.
  // ---------------------------------------------------------------------
  always_comb begin
    sel_we    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (m1_gnt) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else if (m0_gnt) begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  assign ram_en      = m0_gnt | m1_gnt;
  assign ram_we      = sel_we;
  assign ram_addr    = sel_addr[RAM_AW+1:2];
  assign ram_wdata   = sel_wdata;
  assign unused_addr = sel_addr;

  // ---------------------------------------------------------------------
  // Starvation counter and priority FSM.
  // The FSM looks at the counter's next value so that m1 wins in the very
  // cycle after its MAX_WAIT-th loss, not one cycle later.
  // ---------------------------------------------------------------------
  always_comb begin
    wait_nxt = '0;
    if (m1_req && !m1_gnt) begin
      wait_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRIO_M0: begin
        if (wait_nxt == CNT_MAX) state_nxt = FORCE_M1;
      end
      FORCE_M1: begin
        // Leave on the forced grant, or if m1 withdraws its request.
        if (m1_gnt || !m1_req) state_nxt = PRIO_M0;
      end
      default: state_nxt = PRIO_M0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= PRIO_M0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Read-return tracker: remembers whether the last granted access was a
  // read and who issued it. Reset drops any pending response.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend  <= 1'b0;
      rd_owner <= MST_CORE;
    end else begin
      rd_pend  <= ram_en && (sel_we == '0);
      rd_owner <= m1_gnt ? MST_LOADER : MST_CORE;
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == MST_CORE);
  assign m1_rvalid = rd_pend && (rd_owner == MST_LOADER);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter. A simple
// RAM stub sits on the RAM port; a behavioural model (loss count, expected
// read return, reference memory) predicts every output each cycle. Directed
// scenarios are followed by a randomized traffic phase.
module tb_ram_port_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int WORDS    = 2048;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  ram_port_arbiter #(
    .DATA_W(32), .ADDR_W(32), .RAM_AW(11), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM stub: four byte-lane banks, 1-cycle read latency.
  logic [31:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= ram_mem[ram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int          lost;         // consecutive cycles m1 has waited
  bit          pend_v;
  bit          pend_owner;   // 0 = m0, 1 = m1
  logic [31:0] pend_data;
  logic [31:0] ref_mem [WORDS];
  bit          e_g0, e_g1;   // model grants of the cycle just completed

  // Samples captured in the last cycle, for directed checks.
  logic [63:0] obs_g0, obs_g1, obs_en, obs_we, obs_addr;
  logic [63:0] obs_rv0, obs_rv1, obs_rd0, obs_rd1;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic model_reset();
    lost   = 0;
    pend_v = 0;
  endtask

  task automatic set_m0(input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // One clock cycle: inputs already applied; sample at negedge, compare to
  // the model, advance the model for the coming edge, return at edge+1.
  task automatic cycle();
    logic [3:0]  x_we;
    logic [31:0] x_addr, x_wdata;
    bit          x_rv0, x_rv1;
    @(negedge clk);
    if (!rstn) begin
      e_g0 = 0; e_g1 = 0;
    end else begin
      e_g1 = m1_req && (!m0_req || lost >= MAX_WAIT);
      e_g0 = m0_req && !e_g1;
    end
    x_we = '0; x_addr = '0; x_wdata = '0;
    if (e_g1)      begin x_we = m1_we; x_addr = m1_addr; x_wdata = m1_wdata; end
    else if (e_g0) begin x_we = m0_we; x_addr = m0_addr; x_wdata = m0_wdata; end
    x_rv0 = pend_v && !pend_owner;
    x_rv1 = pend_v && pend_owner;

    obs_g0 = 64'(m0_gnt);     obs_g1 = 64'(m1_gnt);
    obs_en = 64'(ram_en);     obs_we = 64'(ram_we);
    obs_addr = 64'(ram_addr);
    obs_rv0 = 64'(m0_rvalid); obs_rv1 = 64'(m1_rvalid);
    obs_rd0 = 64'(m0_rdata);  obs_rd1 = 64'(m1_rdata);

    check("m0_gnt",    obs_g0, 64'(e_g0));
    check("m1_gnt",    obs_g1, 64'(e_g1));
    check("ram_en",    obs_en, 64'(e_g0 || e_g1));
    check("ram_we",    obs_we, 64'(x_we));
    check("ram_addr",  obs_addr, 64'(widx(x_addr)));
    check("ram_wdata", 64'(ram_wdata), 64'(x_wdata));
    check("m0_rvalid", obs_rv0, 64'(x_rv0));
    check("m1_rvalid", obs_rv1, 64'(x_rv1));
    check("m0_rdata",  obs_rd0, x_rv0 ? 64'(pend_data) : 64'd0);
    check("m1_rdata",  obs_rd1, x_rv1 ? 64'(pend_data) : 64'd0);

    if (!rstn) begin
      model_reset();
    end else begin
      lost   = (m1_req && !e_g1) ? ((lost < MAX_WAIT) ? lost + 1 : lost) : 0;
      pend_v = (e_g0 || e_g1) && (x_we == 4'b0000);
      pend_owner = e_g1;
      if (e_g0 || e_g1) begin
        pend_data = ref_mem[widx(x_addr)];
        for (int b = 0; b < 4; b++)
          if (x_we[b]) ref_mem[widx(x_addr)][8*b +: 8] = x_wdata[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 31)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rand_we();
    return ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    rstn = 1'b0;
    // Requests high during reset: grants must stay low.
    set_m0(1, 4'hF, 32'h10, 32'h1234_5678);
    set_m1(1, 4'hF, 32'h20, 32'h8765_4321);
    @(posedge clk); #1;
    cycle();
    check("rst_m0_gnt", obs_g0, 0);
    check("rst_m1_gnt", obs_g1, 0);
    check("rst_ram_en", obs_en, 0);
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    rstn = 1'b1;
    cycle();
    check("idle_ram_en", obs_en, 0);

    // m0 write then read of word 4.
    set_m0(1, 4'hF, 32'h10, 32'hDEAD_BEEF); cycle();
    set_m0(1, 4'h0, 32'h10, 32'h0);         cycle();
    check("t1_m0_gnt", obs_g0, 1);
    check("t1_addr", obs_addr, 4);
    set_m0(0, 0, 0, 0); cycle();
    check("t1_rvalid", obs_rv0, 1);
    check("t1_rdata", obs_rd0, 64'h0000_0000_DEAD_BEEF);
    check("t1_m1_rvalid", obs_rv1, 0);

    // m1 full write, then byte write to lane 2, then read back.
    set_m1(1, 4'hF, 32'h20, 32'h1122_3344);       cycle();
    set_m1(1, 4'b0100, 32'h22, 32'h00AB_0000);    cycle();
    check("t2_gnt", obs_g1, 1);
    check("t2_we", obs_we, 4'b0100);
    check("t2_addr", obs_addr, 8);
    set_m1(1, 4'h0, 32'h20, 32'h0); cycle();
    set_m1(0, 0, 0, 0);             cycle();
    check("t2_rvalid", obs_rv1, 1);
    check("t2_rdata", obs_rd1, 64'h0000_0000_11AB_3344);

    // Contention: m1 force-granted at cycle MAX_WAIT, m0 again after.
    for (int k = 0; k < 10; k++) begin
      set_m0(1, 4'h0, 32'(k * 4), 0);
      set_m1(1, 4'h0, 32'h40, 0);
      cycle();
      check("t3_m0_gnt", obs_g0, (k != MAX_WAIT) ? 1 : 0);
      check("t3_m1_gnt", obs_g1, (k == MAX_WAIT) ? 1 : 0);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0); cycle();

    // Alternating reads: responses land on the right master.
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
      end else if (k % 2 == 0) begin
        set_m0(1, 0, 32'h10, 0); set_m1(0, 0, 0, 0);
      end else begin
        set_m0(0, 0, 0, 0); set_m1(1, 0, 32'h20, 0);
      end
      cycle();
      if (k > 0) begin
        check("t4_rv0", obs_rv0, ((k - 1) % 2 == 0) ? 1 : 0);
        check("t4_rv1", obs_rv1, ((k - 1) % 2 == 1) ? 1 : 0);
        check("t4_rd0", obs_rd0, ((k - 1) % 2 == 0) ? 64'hDEAD_BEEF : 0);
        check("t4_rd1", obs_rd1, ((k - 1) % 2 == 1) ? 64'h11AB_3344 : 0);
      end
    end

    // Reset right after an m1 read grant: response dropped, state cleared.
    set_m1(1, 0, 32'h20, 0); cycle();
    check("t5_gnt", obs_g1, 1);
    rstn = 1'b0;
    model_reset();
    set_m1(0, 0, 0, 0);
    cycle();
    check("t5_no_rvalid", obs_rv1, 0);
    rstn = 1'b1;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      set_m0(1, 0, 32'h0, 0); set_m1(1, 0, 32'h4, 0);
      cycle();
      check("t5_m1_gnt", obs_g1, (k == MAX_WAIT) ? 1 : 0);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0); cycle();

    // Aliasing read.
    set_m0(1, 0, 32'h8000_2004, 0); cycle();
    check("t6_addr", obs_addr, 1);
    check("t6_en", obs_en, 1);
    set_m0(0, 0, 0, 0); cycle();
    check("t6_rvalid", obs_rv0, 1);
    check("t6_idle_en", obs_en, 0);

    // m1 withdraws while force-granted: m0 proceeds, priority restored.
    for (int k = 0; k < MAX_WAIT; k++) begin
      set_m0(1, 0, 32'h0, 0); set_m1(1, 0, 32'h8, 0); cycle();
    end
    set_m1(0, 0, 0, 0); cycle();
    check("t7_drop_m0", obs_g0, 1);
    check("t7_drop_m1", obs_g1, 0);
    set_m1(1, 0, 32'h8, 0); cycle();
    check("t7_prio_m0", obs_g0, 1);
    check("t7_prio_m1", obs_g1, 0);
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0); cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (m0_req ? e_g0 : 1'b1) begin
        if ($urandom_range(0, 3) != 0)
          set_m0(1, rand_we(), rand_addr(), $urandom);
        else
          set_m0(0, 0, 0, 0);
      end
      if (m1_req ? e_g1 : 1'b1) begin
        if ($urandom_range(0, 1) != 0)
          set_m1(1, rand_we(), rand_addr(), $urandom);
        else
          set_m1(0, 0, 0, 0);
      end
      if (n == 1500) begin
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
      end
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter that shares the SoC's single data-RAM port (four byte-lane RAM banks, 1-cycle read latency) between the core load/store port (m0) and a program loader/debug port (m1). m0 is favoured with fixed priority. A starvation counter forces a grant to m1 after a bounded wait. The block routes read data back to the issuing master with a 1-cycle-delayed valid. It sits in `riscv_soc` between `riscv` / loader and `ram`, replacing the direct core-to-RAM connection.

## Interface
Parameters:
- `DATA_W`, 32, data width (4 byte lanes)
- `ADDR_W`, 32, master address width (byte address)
- `RAM_AW`, 11, RAM word-address width (2^13 bytes / 4)
- `MAX_WAIT`, 8, consecutive lost cycles before m1 is force-granted (≥1)

Ports:
- `clk` in 1: the single clock; all state on rising edge
- `rstn` in 1: reset, asynchronous assert, active-low
- `m0_req` in 1: core request, held with payload stable until granted
- `m0_we` in 4: byte write strobes; 4'b0000 = read
- `m0_addr` in ADDR_W: byte address
- `m0_wdata` in DATA_W: write data (lane-aligned)
- `m0_gnt` out 1: grant; transfer occurs on `req && gnt` at the clock edge
- `m0_rdata` out DATA_W: read data
- `m0_rvalid` out 1: read data valid, one pulse per granted read
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rdata`, `m1_rvalid`: same as m0 for the loader
- `ram_en` out 1: RAM access enable
- `ram_we` out 4: RAM byte write enables
- `ram_addr` out RAM_AW: RAM word address
- `ram_wdata` out DATA_W: RAM write data
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after `ram_en` with `ram_we==0`

## Operation
- Grant is combinational from the current `req` inputs and the registered state. At most one `gnt` is high. No grant is issued without a `req`.
- FSM has two states.
  - `PRIO_M0` (reset state): m0 wins when both request.
  - `FORCE_M1`: m1 wins when both request.
- `wait_cnt` has width clog2(MAX_WAIT+1) and resets to 0.
  - Increments each cycle `m1_req && !m1_gnt`.
  - Clears on an m1 grant or whenever `m1_req` is low.
  - Saturates at MAX_WAIT.
- `PRIO_M0` → `FORCE_M1` when `wait_cnt` reaches MAX_WAIT.
- `FORCE_M1` → `PRIO_M0` on the m1 grant, which is the only grant in that state. m0 waits.
- RAM outputs mux the granted master's payload.
  - `ram_en = |gnt`.
  - `ram_addr = addr[RAM_AW+1:2]`.
  - `addr[1:0]` is ignored. Upper address bits are ignored, so the RAM aliases.
  - When no grant: `ram_we`, `ram_addr` and `ram_wdata` are driven 0.
- Read return: a 1-bit register `rd_pend` and a 1-bit register `rd_owner` capture a granted read (`we==0`).
  - Next cycle, the owner's `rvalid` is 1 and its `rdata` = `ram_rdata`.
  - The non-owner `rdata` = 0.
- Writes produce no response; they complete at the grant edge.
- Back-to-back accesses from either master are accepted every cycle (full throughput).

## Timing
- Reset values: all `gnt`, `rvalid`, `ram_en`, `ram_we` = 0; `ram_addr`/`ram_wdata`/`rdata` = 0; FSM = `PRIO_M0`; `wait_cnt` = 0; `rd_pend` = 0.
- While `rstn` is low, grants are forced 0 regardless of `req`.
- Grant latency: 0 cycles when uncontested. m1 under continuous m0 traffic is granted no later than MAX_WAIT+1 cycles after raising `req`.
- Read latency: `rvalid` is 1 cycle after the grant edge.
- Simultaneous first request from both masters in `PRIO_M0`: m0 is granted.
- Reset asserted mid-operation: a pending `rvalid` is dropped and not replayed. Counter and FSM return to reset values.
- `m1_req` dropped while in `FORCE_M1` (protocol violation, tolerated): FSM returns to `PRIO_M0` next cycle, and m0 is granted normally in that cycle.
- MAX_WAIT=1: m1 alternates with m0 under mutual saturation.

## Structure
- Package `riscv_mem_pkg` holds:
  - `BYTE_LANES` = 4
  - `RAM_AW` default
  - master ID constants `MST_CORE` = 0, `MST_LOADER` = 1
  - FSM state enum `arb_state_t`
- No sub-module. The arbiter, counter and read-return tracker are a single module of roughly 150–250 lines.

## Test plan
- m0 read only, addr 0x0000_0010, RAM word 4 = 0xDEADBEEF → `m0_gnt` same cycle, `ram_addr` = 4, next cycle `m0_rvalid` = 1 and `m0_rdata` = 0xDEADBEEF. `m1_rvalid` stays 0.
- m1 byte write, `we` = 4'b0100, addr 0x0000_0022, wdata 0x00AB0000 → `ram_we` = 4'b0100, `ram_addr` = 8. A subsequent read of word 8 shows only byte 2 changed.
- Both request in the same cycle, m0 continuously → m0 granted cycles 0–7, m1 granted at cycle 8 (MAX_WAIT=8), m0 granted again at cycle 9.
- Alternating m0 read / m1 read on consecutive cycles → each `rvalid` appears on the correct master one cycle after its grant, with no cross-routing of `rdata`.
- `rstn` pulsed low for 1 cycle immediately after an m1 read grant → no `m1_rvalid` pulse. FSM is `PRIO_M0` and `wait_cnt` = 0 after release.
- Address 0x8000_2004 read → aliases to `ram_addr` = 1. `ram_en` = 0 in every cycle with no request.
